level_sequencer: RTL
====================

// Module: level_sequencer
// PURPOSE
//  Parametrised game-level controller for the block stacker. Steps the player
//  through NUM_LEVELS rows and emits the per-level block speed and block count.
//  Block count shrinks with partial hits, exactly as in a real stacker.
//  Optionally grants retries. Feeds the row mover/draw FSM; consumes its row-placed result.
// PARAMETERS
//  NUM_LEVELS   15          levels to win (>=2)
//  LEVEL_W      4           width of curr_level (holds NUM_LEVELS)
//  PERIOD_W     26          width of speed_count
//  BASE_PERIOD  50_000_000  clk cycles per block step at level 1
//  PERIOD_STEP  5_000_000   period reduction per level advance
//  MIN_PERIOD   10_000_000  period floor (saturation)
//  BLOCKS_W     3           width of block counts
//  MAX_BLOCKS   3           block count at level 1
//  SHRINK_EVERY 5           cap drops by 1 after every SHRINK_EVERY levels, floor 1
//  RETRIES      2           lives available when LEVEL_RETRY_EN defined
// PORTS
//  clk          in   1         system clock; one clock domain, rising edge
//  resetn       in   1         synchronous, active-low reset
//  go           in   1         start current level / restart after WIN or OVER
//  place_done   in   1         1-cycle pulse: row has been placed
//  hit_blocks   in   BLOCKS_W  blocks overlapping row below; valid with place_done; 0 = miss
//  speed_count  out  PERIOD_W  current step period in clk cycles
//  num_blocks   out  BLOCKS_W  blocks in the moving row
//  curr_level   out  LEVEL_W   1-based level
//  active       out  1         high in PLAY
//  level_up     out  1         1-cycle pulse on advance
//  game_won     out  1         high in WIN
//  game_over    out  1         high in OVER
// BEHAVIOUR
//  Reset: state=WAIT, curr_level=1, speed_count=BASE_PERIOD, num_blocks=MAX_BLOCKS,
//   cap=MAX_BLOCKS, shrink counter=0, lives=RETRIES; all pulse and flag outputs 0.
//  States: WAIT (level loaded, idle), PLAY, WIN, OVER. All outputs registered.
//  WAIT: go -> PLAY next edge.
//  PLAY with place_done:
//   - hit_blocks>0, level<NUM_LEVELS -> WAIT. level+1; level_up=1 for one cycle.
//     speed_count=max(speed_count-PERIOD_STEP, MIN_PERIOD); no underflow wrap.
//     shrink counter increments. On reaching SHRINK_EVERY it clears, and cap=max(cap-1,1).
//     num_blocks=min(hit_blocks, num_blocks, new cap).
//   - hit_blocks>0, level==NUM_LEVELS -> WIN. Level and period hold.
//   - hit_blocks==0 -> OVER; see CONFIGURATION.
//   - hit_blocks>num_blocks is treated as num_blocks.
//  place_done outside PLAY: ignored. go in PLAY: ignored.
//  go together with place_done in the same cycle: only the state's own rule applies.
//  WIN/OVER: hold outputs. go -> full reinitialise to reset values (state WAIT).
//  Reset mid-PLAY: returns to reset values on that edge; no level_up/over pulse.
//  Latency: every response appears one clk after the triggering input.
// CONFIGURATION
//  LEVEL_RETRY_EN defined:
//   - A miss with lives>0 -> WAIT at the same level. lives-1; num_blocks=cap; period unchanged.
//   - A miss with lives==0 -> OVER.
//   - Restart reloads lives=RETRIES.
//  LEVEL_RETRY_EN undefined: lives logic absent; any miss -> OVER.
// STRUCTURE
//  Package level_pkg:
//   - state enum {WAIT, PLAY, WIN, OVER}
//   - LEVEL_W, BLOCKS_W, PERIOD_W defaults
//   - a sat_sub helper function
//  Sub-module level_period_gen: saturating period register.
//   - Inputs: load (reset/restart), step (advance).
//   - Output: speed_count.
//  FSM, cap/shrink counter and block min logic stay in level_sequencer.
// TESTING
//  1. Reset, go, place_done hit=3 -> level 2, speed 45_000_000, blocks 3, level_up 1 cycle.
//  2. Advance 9 levels with hits -> speed saturates at 10_000_000 at level 9 and stays at level 10.
//  3. Advance to level 6 with hit=3 -> num_blocks=2 (cap); level 11 -> 1; partial hit=1 earlier -> 1.
//  4. Hit on level 15 -> game_won=1; go -> level 1, speed 50_000_000, blocks 3.
//  5. hit=0 on level 4 without macro -> game_over; with LEVEL_RETRY_EN -> level 4 WAIT, lives 1.
//  6. Pulse resetn low mid-PLAY at level 7; place_done outside PLAY -> all outputs at reset values, no effect.

Source files
------------

// File: rtl/level_sequencer_pkg.sv
// Shared types and widths for the block-stacker level controller.
// Optional retry support is enabled with the LEVEL_RETRY_EN macro (see level_sequencer).
package level_pkg;

  localparam int LEVEL_W  = 4;
  localparam int BLOCKS_W = 3;
  localparam int PERIOD_W = 26;

  typedef enum logic [1:0] {
    WAIT,
    PLAY,
    WIN,
    OVER
  } state_t;

  // Subtract with a floor; never wraps below zero or below the floor.
  function automatic logic [PERIOD_W-1:0] sat_sub(
    input logic [PERIOD_W-1:0] value,
    input logic [PERIOD_W-1:0] step,
    input logic [PERIOD_W-1:0] floor
  );
    logic [PERIOD_W-1:0] diff;
    diff = value - step;
    if ((value < step) || (diff < floor)) begin
      sat_sub = floor;
    end else begin
      sat_sub = diff;
    end
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Handshake/status bundle between the level sequencer and the row mover/draw FSM.
interface level_sequencer_if;
  import level_pkg::*;

  logic                go;
  logic                place_done;
  logic [BLOCKS_W-1:0] hit_blocks;
  logic [PERIOD_W-1:0] speed_count;
  logic [BLOCKS_W-1:0] num_blocks;
  logic [LEVEL_W-1:0]  curr_level;
  logic                active;
  logic                level_up;
  logic                game_won;
  logic                game_over;

  modport master (
    output go, place_done, hit_blocks,
    input  speed_count, num_blocks, curr_level, active, level_up, game_won, game_over
  );

  modport slave (
    input  go, place_done, hit_blocks,
    output speed_count, num_blocks, curr_level, active, level_up, game_won, game_over
  );

endinterface

// File: rtl/level_sequencer_period_gen.sv
// Block step period register: loads the level-1 period, then shortens by a
// fixed step on every level advance, saturating at a floor.
module level_period_gen
  import level_pkg::*;
#(
  parameter int BASE_PERIOD = 50_000_000,
  parameter int PERIOD_STEP = 5_000_000,
  parameter int MIN_PERIOD  = 10_000_000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_load,
  input  logic                i_step,
  output logic [PERIOD_W-1:0] o_speedCount
);

  localparam logic [PERIOD_W-1:0] BASE_P = PERIOD_W'(BASE_PERIOD);
  localparam logic [PERIOD_W-1:0] STEP_P = PERIOD_W'(PERIOD_STEP);
  localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(MIN_PERIOD);

  logic [PERIOD_W-1:0] r_period;

  always_ff @(posedge clk) begin
    if (!resetn || i_load) begin
      r_period <= BASE_P;
    end else if (i_step) begin
      r_period <= sat_sub(r_period, STEP_P, MIN_P);
    end
  end

  assign o_speedCount = r_period;

endmodule

// File: rtl/level_sequencer.sv
// Game-level controller for the block stacker: level, speed and row width per level.
// Define LEVEL_RETRY_EN to grant RETRIES extra attempts on a missed row.
module level_sequencer
  import level_pkg::*;
#(
  parameter int NUM_LEVELS   = 15,
  parameter int BASE_PERIOD  = 50_000_000,
  parameter int PERIOD_STEP  = 5_000_000,
  parameter int MIN_PERIOD   = 10_000_000,
  parameter int MAX_BLOCKS   = 3,
  parameter int SHRINK_EVERY = 5
`ifdef LEVEL_RETRY_EN
  , parameter int RETRIES    = 2
`endif
) (
  input logic               clk,
  input logic               resetn,
  level_sequencer_if.slave  bus
);

  localparam int SHRINK_W = $clog2(SHRINK_EVERY + 1);
  localparam logic [LEVEL_W-1:0]  LAST_LEVEL  = LEVEL_W'(NUM_LEVELS);
  localparam logic [LEVEL_W-1:0]  FIRST_LEVEL = LEVEL_W'(1);
  localparam logic [BLOCKS_W-1:0] FULL_ROW    = BLOCKS_W'(MAX_BLOCKS);
  localparam logic [BLOCKS_W-1:0] ONE_BLOCK   = BLOCKS_W'(1);
  localparam logic [SHRINK_W-1:0] SHRINK_LAST = SHRINK_W'(SHRINK_EVERY - 1);

`ifdef LEVEL_RETRY_EN
  localparam int LIVES_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(RETRIES);
  logic [LIVES_W-1:0] r_lives, w_nextLives;
`endif

  state_t              r_state, w_nextState;
  logic [LEVEL_W-1:0]  r_level, w_nextLevel;
  logic [BLOCKS_W-1:0] r_numBlocks, w_nextBlocks;
  logic [BLOCKS_W-1:0] r_cap, w_nextCap;
  logic [SHRINK_W-1:0] r_shrinkCnt, w_nextShrink;
  logic                r_active, r_levelUp, r_won, r_over;
  logic                w_levelUp, w_load, w_step;
  logic [BLOCKS_W-1:0] w_hitClamped, w_capAfter, w_advBlocks;
  logic                w_shrinkWrap;
  logic [PERIOD_W-1:0] w_speedCount;

  // A hit wider than the moving row cannot happen physically; clamp it.
  assign w_hitClamped = (bus.hit_blocks > r_numBlocks) ? r_numBlocks : bus.hit_blocks;
  assign w_shrinkWrap = (r_shrinkCnt == SHRINK_LAST);
  assign w_capAfter   = (w_shrinkWrap && (r_cap > ONE_BLOCK)) ? (r_cap - ONE_BLOCK) : r_cap;
  assign w_advBlocks  = (w_hitClamped < w_capAfter) ? w_hitClamped : w_capAfter;

  always_comb begin
    w_nextState  = r_state;
    w_nextLevel  = r_level;
    w_nextBlocks = r_numBlocks;
    w_nextCap    = r_cap;
    w_nextShrink = r_shrinkCnt;
    w_levelUp    = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
`ifdef LEVEL_RETRY_EN
    w_nextLives  = r_lives;
`endif
    case (r_state)
      WAIT: begin
        if (bus.go) w_nextState = PLAY;
      end
      PLAY: begin
        if (bus.place_done) begin
          if (bus.hit_blocks != '0) begin
            if (r_level < LAST_LEVEL) begin
              w_nextState  = WAIT;
              w_nextLevel  = r_level + FIRST_LEVEL;
              w_levelUp    = 1'b1;
              w_step       = 1'b1;
              w_nextShrink = w_shrinkWrap ? '0 : (r_shrinkCnt + SHRINK_W'(1));
              w_nextCap    = w_capAfter;
              w_nextBlocks = w_advBlocks;
            end else begin
              w_nextState = WIN;
            end
          end else begin
`ifdef LEVEL_RETRY_EN
            if (r_lives != '0) begin
              w_nextState  = WAIT;
              w_nextLives  = r_lives - LIVES_W'(1);
              w_nextBlocks = r_cap;
            end else begin
              w_nextState = OVER;
            end
`else
            w_nextState = OVER;
`endif
          end
        end
      end
      WIN, OVER: begin
        if (bus.go) begin
          w_nextState  = WAIT;
          w_nextLevel  = FIRST_LEVEL;
          w_nextBlocks = FULL_ROW;
          w_nextCap    = FULL_ROW;
          w_nextShrink = '0;
          w_load       = 1'b1;
`ifdef LEVEL_RETRY_EN
          w_nextLives  = FULL_LIVES;
`endif
        end
      end
      default: w_nextState = WAIT;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= WAIT;
      r_level     <= FIRST_LEVEL;
      r_numBlocks <= FULL_ROW;
      r_cap       <= FULL_ROW;
      r_shrinkCnt <= '0;
      r_active    <= 1'b0;
      r_levelUp   <= 1'b0;
      r_won       <= 1'b0;
      r_over      <= 1'b0;
`ifdef LEVEL_RETRY_EN
      r_lives     <= FULL_LIVES;
`endif
    end else begin
      r_state     <= w_nextState;
      r_level     <= w_nextLevel;
      r_numBlocks <= w_nextBlocks;
      r_cap       <= w_nextCap;
      r_shrinkCnt <= w_nextShrink;
      r_active    <= (w_nextState == PLAY);
      r_levelUp   <= w_levelUp;
      r_won       <= (w_nextState == WIN);
      r_over      <= (w_nextState == OVER);
`ifdef LEVEL_RETRY_EN
      r_lives     <= w_nextLives;
`endif
    end
  end

  level_period_gen #(
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_STEP (PERIOD_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_periodGen (
    .clk          (clk),
    .resetn       (resetn),
    .i_load       (w_load),
    .i_step       (w_step),
    .o_speedCount (w_speedCount)
  );

  assign bus.speed_count = w_speedCount;
  assign bus.num_blocks  = r_numBlocks;
  assign bus.curr_level  = r_level;
  assign bus.active      = r_active;
  assign bus.level_up    = r_levelUp;
  assign bus.game_won    = r_won;
  assign bus.game_over   = r_over;

endmodule
